pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It drives the enable and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC write enable. It resolves three hazards: load-use, taken branch resolved in MEM, and multi-cycle data-memory access through a req/ack handshake. It sits beside the datapath, reads hazard-relevant fields out of the pipeline registers, and owns no datapath state.

## Interface
- CNT_W, 32, width of the performance counters
- REG_AW, 5, register-file address width
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous, active-low reset
- IDEX_MemRead_i  in  1  instruction in ID/EX is a load
- IDEX_RDaddr_i  in  REG_AW  destination register of the ID/EX instruction
- IFID_RS1addr_i / IFID_RS2addr_i  in  REG_AW  source registers of the IF/ID instruction
- EXMEM_Branch_i, EXMEM_Zero_i  in  1  branch and condition of the EX/MEM instruction
- EXMEM_MemRead_i, EXMEM_MemWrite_i  in  1  memory operation held in EX/MEM
- mem_ack_i  in  1  data memory has completed the current request
- mem_req_o  out  1  data-memory request
- PCWrite_o, IFID_en_o, IDEX_en_o, EXMEM_en_o, MEMWB_en_o  out  1  stage register enables
- IFID_flush_o, IDEX_flush_o, EXMEM_flush_o  out  1  load a bubble instead of the incoming data
- PCSrc_o  out  1  select the branch target for the PC
- stall_cnt_o, flush_cnt_o  out  CNT_W  performance counters

## Operation
- FSM states:
  - RUN is the reset state.
  - WAIT covers an outstanding memory request.
- mem_op = EXMEM_MemRead_i | EXMEM_MemWrite_i.
- RUN, mem_op=1:
  - mem_req_o=1.
  - If mem_ack_i=1 in the same cycle, there is no stall and the state stays RUN.
  - Otherwise all enables are 0 (full freeze) and the next state is WAIT.
- WAIT:
  - mem_req_o=1 and all enables are 0.
  - When mem_ack_i=1, all enables are 1 and the next state is RUN.
  - mem_req_o stays high from request until ack, with no drop.
- Load-use: IDEX_MemRead_i & (IDEX_RDaddr_i≠0) & (IDEX_RDaddr_i==IFID_RS1addr_i | IDEX_RDaddr_i==IFID_RS2addr_i).
  - Response: PCWrite_o=0, IFID_en_o=0, IDEX_flush_o=1.
  - Later stages keep advancing.
- Taken branch: EXMEM_Branch_i & EXMEM_Zero_i.
  - Response: PCSrc_o=1 and IFID_flush_o=IDEX_flush_o=EXMEM_flush_o=1.
  - All enables stay 1.
- Priority: memory freeze > branch flush > load-use.
  - A freeze suppresses all flushes.
  - A branch flush overrides load-use, because the dependent instruction is squashed.
- Register x0 never triggers load-use.
- Default (no hazard): all enables 1, flushes 0, PCSrc_o 0, mem_req_o 0.

## Timing
- The FSM state is registered. All outputs are combinational from state and inputs, with no added latency.
- Load-use costs exactly 1 bubble cycle.
- A taken branch costs 3 squashed instructions.
- A memory op acked N cycles after the request begins costs N stall cycles; an ack in the same cycle costs 0.
- While rst_i=0:
  - The state is RUN.
  - mem_req_o, PCSrc_o, every flush and every enable are 0.
  - The counters are 0.
- Reset asserted in WAIT aborts the request: mem_req_o drops asynchronously.
- mem_ack_i is ignored when mem_req_o=0.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - stall_cnt_o increments on every cycle with PCWrite_o=0.
  - flush_cnt_o increments on every taken-branch cycle.
  - Both counters saturate at 2^CNT_W−1.
- Not defined:
  - No counter flops exist.
  - Both ports are tied to 0.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN, WAIT)
  - REG_AW default
  - the x0 address constant
- One combinational sub-module, hazard_detect, computes the load-use condition from the ID/EX and IF/ID fields.
- The FSM, priority logic and counters stay in pipe_ctrl.

## Test plan
- Load x5 in ID/EX with IF/ID rs1=x5 -> one cycle of PCWrite_o=0, IFID_en_o=0, IDEX_flush_o=1, then normal; the same case with rd=x0 -> no stall.
- Taken branch (Branch=1, Zero=1) -> PCSrc_o=1 and all three flushes 1 for one cycle; Zero=0 -> no flush.
- Store in EX/MEM with ack 3 cycles after request -> mem_req_o high 4 cycles, enables 0 for 3 cycles, then all 1 and back to RUN; ack in the same cycle -> 0 stalls.
- Load-use and a pending memory wait together -> full freeze with IDEX_flush_o=0; on ack the load-use bubble is inserted next.
- rst_i pulled low in WAIT -> mem_req_o=0 immediately, state RUN after release, counters 0.
- With PIPE_PERF_CNT_EN: 3 stall cycles plus 2 taken branches -> stall_cnt_o=3, flush_cnt_o=2; with CNT_W=2, 5 stalls -> stall_cnt_o=3 (saturated).

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared definitions for the pipeline sequencing controller.
//                - state_t        : controller FSM state encoding (RUN, WAIT)
//                - REG_AW_DEFAULT : default register-file address width
//                - c_x0_addr      : address of the hard-wired zero register
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  localparam int unsigned REG_AW_DEFAULT = 5;

  // x0 is hard-wired to zero, so writing it never creates a dependency.
  localparam logic [REG_AW_DEFAULT-1:0] c_x0_addr = '0;

  typedef enum logic [0:0] {
    RUN  = 1'b0,   // pipeline flowing, no memory request outstanding
    WAIT = 1'b1    // data-memory request issued, waiting for ack
  } state_t;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational load-use detector. Flags when the instruction
//                in ID/EX is a load whose destination register is read by the
//                instruction in IF/ID. The zero register never matches.
//  Ports       : i_idex_mem_read  - ID/EX instruction is a load
//                i_idex_rd_addr   - ID/EX destination register
//                i_ifid_rs1_addr  - IF/ID source register 1
//                i_ifid_rs2_addr  - IF/ID source register 2
//                o_load_use       - load-use hazard present
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              i_idex_mem_read,
  input  logic [REG_AW-1:0] i_idex_rd_addr,
  input  logic [REG_AW-1:0] i_ifid_rs1_addr,
  input  logic [REG_AW-1:0] i_ifid_rs2_addr,
  output logic              o_load_use
);

  logic w_rd_nonzero;
  logic w_rs1_match;
  logic w_rs2_match;

  assign w_rd_nonzero = (i_idex_rd_addr != REG_AW'(c_x0_addr));
  assign w_rs1_match  = (i_idex_rd_addr == i_ifid_rs1_addr);
  assign w_rs2_match  = (i_idex_rd_addr == i_ifid_rs2_addr);

  assign o_load_use = i_idex_mem_read & w_rd_nonzero & (w_rs1_match | w_rs2_match);

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Pipeline sequencing controller for the 5-stage RISC-V core.
//                Drives stage-register enables/flushes, PC write enable and
//                PC source select. Resolves, in priority order:
//                  1. multi-cycle data-memory access (full freeze, req/ack)
//                  2. taken branch resolved in MEM (flush IF/ID, ID/EX, EX/MEM)
//                  3. load-use (hold PC and IF/ID, bubble into ID/EX)
//                All outputs are combinational from the FSM state and inputs.
//                While rst_i is low every control output is forced to 0.
//  Ports       : clk_i, rst_i (async, active-low)
//                IDEX_*/IFID_*/EXMEM_* : hazard fields from pipeline registers
//                mem_ack_i / mem_req_o : data-memory handshake
//                PCWrite_o, *_en_o     : stage register enables
//                *_flush_o             : load bubble into stage register
//                PCSrc_o               : select branch target for PC
//                stall_cnt_o/flush_cnt_o : performance counters
//  Config      : define PIPE_PERF_CNT_EN to build the saturating performance
//                counters; otherwise both counter ports are tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              IDEX_MemRead_i,
  input  logic [REG_AW-1:0] IDEX_RDaddr_i,
  input  logic [REG_AW-1:0] IFID_RS1addr_i,
  input  logic [REG_AW-1:0] IFID_RS2addr_i,
  input  logic              EXMEM_Branch_i,
  input  logic              EXMEM_Zero_i,
  input  logic              EXMEM_MemRead_i,
  input  logic              EXMEM_MemWrite_i,
  input  logic              mem_ack_i,
  output logic              mem_req_o,
  output logic              PCWrite_o,
  output logic              IFID_en_o,
  output logic              IDEX_en_o,
  output logic              EXMEM_en_o,
  output logic              MEMWB_en_o,
  output logic              IFID_flush_o,
  output logic              IDEX_flush_o,
  output logic              EXMEM_flush_o,
  output logic              PCSrc_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  state_t r_state;
  state_t w_state_next;

  logic w_mem_op;
  logic w_branch_taken;
  logic w_load_use;
  logic w_freeze;

  assign w_mem_op       = EXMEM_MemRead_i | EXMEM_MemWrite_i;
  assign w_branch_taken = EXMEM_Branch_i & EXMEM_Zero_i;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .i_idex_mem_read (IDEX_MemRead_i),
    .i_idex_rd_addr  (IDEX_RDaddr_i),
    .i_ifid_rs1_addr (IFID_RS1addr_i),
    .i_ifid_rs2_addr (IFID_RS2addr_i),
    .o_load_use      (w_load_use)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_freeze      = 1'b0;
    mem_req_o     = 1'b0;
    PCWrite_o     = 1'b1;
    IFID_en_o     = 1'b1;
    IDEX_en_o     = 1'b1;
    EXMEM_en_o    = 1'b1;
    MEMWB_en_o    = 1'b1;
    IFID_flush_o  = 1'b0;
    IDEX_flush_o  = 1'b0;
    EXMEM_flush_o = 1'b0;
    PCSrc_o       = 1'b0;

    // mem_ack_i is only looked at where mem_req_o is driven high.
    case (r_state)
      RUN: begin
        if (w_mem_op) begin
          mem_req_o = 1'b1;
          if (!mem_ack_i) begin
            w_freeze     = 1'b1;
            w_state_next = WAIT;
          end
        end
      end
      WAIT: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          w_state_next = RUN;
        end else begin
          w_freeze = 1'b1;
        end
      end
      default: begin
        w_state_next = RUN;
      end
    endcase

    // Freeze dominates and suppresses every flush. A taken branch squashes
    // the dependent instruction, so it overrides the load-use bubble. On the
    // ack cycle the freeze lifts and any pending load-use is handled then.
    if (w_freeze) begin
      PCWrite_o  = 1'b0;
      IFID_en_o  = 1'b0;
      IDEX_en_o  = 1'b0;
      EXMEM_en_o = 1'b0;
      MEMWB_en_o = 1'b0;
    end else if (w_branch_taken) begin
      PCSrc_o       = 1'b1;
      IFID_flush_o  = 1'b1;
      IDEX_flush_o  = 1'b1;
      EXMEM_flush_o = 1'b1;
    end else if (w_load_use) begin
      PCWrite_o    = 1'b0;
      IFID_en_o    = 1'b0;
      IDEX_flush_o = 1'b1;
    end

    // Reset forces every control low; an outstanding request is dropped
    // immediately without waiting for a clock edge.
    if (!rst_i) begin
      w_state_next  = RUN;
      mem_req_o     = 1'b0;
      PCWrite_o     = 1'b0;
      IFID_en_o     = 1'b0;
      IDEX_en_o     = 1'b0;
      EXMEM_en_o    = 1'b0;
      MEMWB_en_o    = 1'b0;
      IFID_flush_o  = 1'b0;
      IDEX_flush_o  = 1'b0;
      EXMEM_flush_o = 1'b0;
      PCSrc_o       = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // A stall cycle is any cycle where the PC is held; a flush cycle is any
  // cycle where the branch redirect is actually taken (not masked by freeze).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!PCWrite_o && (r_stall_cnt != c_cnt_max)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (PCSrc_o && (r_flush_cnt != c_cnt_max)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule : pipe_ctrl
`default_nettype wire
